// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage MIPS pipe: load-use bubbles, branch flushes, memory-miss holds.
// Define HAZARD_STALL_CNT_EN to build the stall-cycle counter behind stall_cnt_o.
module pipe_hazard_ctrl #(
  parameter int LU_STALL_CYCLES = 1,
  parameter int MEM_TIMEOUT     = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        idex_memread_i,
  input  logic [4:0]  idex_rt_i,
  input  logic [4:0]  ifid_rs_i,
  input  logic [4:0]  ifid_rt_i,
  input  logic        ifid_uses_rt_i,
  input  logic        branch_taken_i,
  input  logic        dmem_req_i,
  input  logic        dmem_ack_i,
  output logic        pc_write_o,
  output logic        ifid_write_o,
  output logic        idex_bubble_o,
  output logic        ifid_flush_o,
  output logic        idex_flush_o,
  output logic        exmem_flush_o,
  output logic        pipe_hold_o,
  output logic        err_o,
  output logic [1:0]  state_o,
  output logic [31:0] stall_cnt_o
);

  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, MEM_WAIT = 2'd2, ERR = 2'd3} state_t;

  localparam logic [3:0] LU_RELOAD  = 4'(LU_STALL_CYCLES - 1);
  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT - 1);
  localparam bit         MULTI_LU   = (LU_STALL_CYCLES > 1);

  state_t     state, state_nxt;
  logic [3:0] lu_cnt, lu_cnt_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       ret_stall, ret_stall_nxt;
  logic       err, err_nxt;
  logic       hazard, miss;

  assign hazard = idex_memread_i & (idex_rt_i != 5'd0) &
                  ((idex_rt_i == ifid_rs_i) | (ifid_uses_rt_i & (idex_rt_i == ifid_rt_i)));
  assign miss   = dmem_req_i & ~dmem_ack_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= RUN;
      lu_cnt    <= 4'd0;
      wait_cnt  <= 8'd0;
      ret_stall <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      lu_cnt    <= lu_cnt_nxt;
      wait_cnt  <= wait_cnt_nxt;
      ret_stall <= ret_stall_nxt;
      err       <= err_nxt;
    end
  end

  // ret_stall remembers whether a miss interrupted a load-use stall, so the ack cycle resumes it.
  always_comb begin
    state_nxt     = state;
    lu_cnt_nxt    = lu_cnt;
    wait_cnt_nxt  = wait_cnt;
    ret_stall_nxt = ret_stall;
    err_nxt       = err;
    unique case (state)
      RUN: begin
        if (miss) begin
          ret_stall_nxt = 1'b0;
          wait_cnt_nxt  = 8'd1;
          state_nxt     = MEM_WAIT;
        end else if (!branch_taken_i && hazard && MULTI_LU) begin
          lu_cnt_nxt = LU_RELOAD;
          state_nxt  = STALL;
        end
      end
      STALL: begin
        if (miss) begin
          ret_stall_nxt = 1'b1;
          wait_cnt_nxt  = 8'd1;
          state_nxt     = MEM_WAIT;
        end else begin
          lu_cnt_nxt = lu_cnt - 4'd1;
          if (lu_cnt == 4'd1) state_nxt = RUN;
        end
      end
      MEM_WAIT: begin
        if (miss) begin
          wait_cnt_nxt = wait_cnt + 8'd1;
          if (wait_cnt == WAIT_LIMIT) begin
            state_nxt = ERR;
            err_nxt   = 1'b1;
          end
        end else begin
          wait_cnt_nxt = 8'd0;
          if (ret_stall) begin
            lu_cnt_nxt = lu_cnt - 4'd1;
            state_nxt  = (lu_cnt == 4'd1) ? RUN : STALL;
          end else if (!branch_taken_i && hazard && MULTI_LU) begin
            lu_cnt_nxt = LU_RELOAD;
            state_nxt  = STALL;
          end else begin
            state_nxt = RUN;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    idex_bubble_o = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_flush_o  = 1'b0;
    exmem_flush_o = 1'b0;
    pipe_hold_o   = 1'b0;
    if (rst_i) begin
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
    end else if (state == ERR || miss) begin
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      pipe_hold_o  = 1'b1;
    end else if (state == STALL || (state == MEM_WAIT && ret_stall)) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_bubble_o = 1'b1;
    end else if (branch_taken_i) begin
      ifid_flush_o  = 1'b1;
      idex_flush_o  = 1'b1;
      exmem_flush_o = 1'b1;
    end else if (hazard) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_bubble_o = 1'b1;
    end
  end

  assign state_o = rst_i ? 2'd0 : state;
  assign err_o   = err & ~rst_i;

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt <= 32'd0;
    end else if (!pc_write_o && stall_cnt != 32'hFFFF_FFFF) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = rst_i ? 32'd0 : stall_cnt;
`else
  assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: three instances (LU_STALL_CYCLES = 1, 2, 3) share stimulus,
// each step checks one instance's outputs against a queued expectation.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, memread, uses_rt, br, req, ack;
  logic [4:0] idex_rt, rs, rt;

  logic        pc_w [1:3];
  logic        ifid_w [1:3];
  logic        bub [1:3];
  logic        ifl [1:3];
  logic        idl [1:3];
  logic        exl [1:3];
  logic        hold [1:3];
  logic        errv [1:3];
  logic [1:0]  st [1:3];
  logic [31:0] scnt [1:3];

  for (genvar g = 1; g <= 3; g++) begin : g_dut
    pipe_hazard_ctrl #(.LU_STALL_CYCLES(g), .MEM_TIMEOUT(16)) u_dut (
      .clk_i(clk), .rst_i(rst),
      .idex_memread_i(memread), .idex_rt_i(idex_rt),
      .ifid_rs_i(rs), .ifid_rt_i(rt), .ifid_uses_rt_i(uses_rt),
      .branch_taken_i(br), .dmem_req_i(req), .dmem_ack_i(ack),
      .pc_write_o(pc_w[g]), .ifid_write_o(ifid_w[g]), .idex_bubble_o(bub[g]),
      .ifid_flush_o(ifl[g]), .idex_flush_o(idl[g]), .exmem_flush_o(exl[g]),
      .pipe_hold_o(hold[g]), .err_o(errv[g]), .state_o(st[g]), .stall_cnt_o(scnt[g])
    );
  end

  int total = 0;
  int bad   = 0;

  int          sel_q [$];
  logic [10:0] exp_q [$];
  string       tag_q [$];

  // Packed view: {pc, ifid, bubble, ifid_flush, idex_flush, exmem_flush, hold, err, state}
  function automatic logic [10:0] mk(logic p, logic f, logic b, logic fl, logic h, logic e, logic [1:0] s);
    return {p, f, b, fl, fl, fl, h, e, s};
  endfunction

  function automatic logic [10:0] obs(int s);
    return {pc_w[s], ifid_w[s], bub[s], ifl[s], idl[s], exl[s], hold[s], errv[s], st[s]};
  endfunction

  task automatic applyStimulus(input int sel, input string tag, input logic r, input logic mr,
                               input logic [4:0] irt, input logic [4:0] irs, input logic [4:0] irtt,
                               input logic urt, input logic b, input logic rq, input logic ak,
                               input logic [10:0] e);
    @(posedge clk);
    #1;
    rst = r; memread = mr; idex_rt = irt; rs = irs; rt = irtt;
    uses_rt = urt; br = b; req = rq; ack = ak;
    sel_q.push_back(sel);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic checkOutput();
    int          s;
    logic [10:0] e;
    string       t;
    logic [10:0] o;
    @(negedge clk);
    total++;
    if (sel_q.size() == 0) begin
      bad++;
      $error("[TB] FAIL scoreboard: observed=empty expected=entry");
    end else begin
      s = sel_q.pop_front();
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      o = obs(s);
      assert (o === e) else begin
        bad++;
        $error("[TB] FAIL %s (dut%0d): observed=%b expected=%b", t, s, o, e);
      end
    end
  endtask

  task automatic step(input int sel, input string tag, input logic r, input logic mr,
                      input logic [4:0] irt, input logic [4:0] irs, input logic [4:0] irtt,
                      input logic urt, input logic b, input logic rq, input logic ak,
                      input logic [10:0] e);
    applyStimulus(sel, tag, r, mr, irt, irs, irtt, urt, b, rq, ak, e);
    checkOutput();
  endtask

  task automatic idle(input int sel, input string tag, input logic [10:0] e);
    step(sel, tag, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, e);
  endtask

  task automatic do_reset(input int sel, input string tag);
    step(sel, tag, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 11'd0);
  endtask

  localparam logic [10:0] DEF    = 11'b11_0_000_0_0_00;
  localparam logic [10:0] BUB_R  = 11'b00_1_000_0_0_00;
  localparam logic [10:0] BUB_S  = 11'b00_1_000_0_0_01;
  localparam logic [10:0] HOLD_R = 11'b00_0_000_1_0_00;
  localparam logic [10:0] HOLD_W = 11'b00_0_000_1_0_10;
  localparam logic [10:0] ERRV   = 11'b00_0_000_1_1_11;

  initial begin
    logic [31:0] exp_cnt;
    rst = 1'b1; memread = 1'b0; idex_rt = 5'd0; rs = 5'd0; rt = 5'd0;
    uses_rt = 1'b0; br = 1'b0; req = 1'b0; ack = 1'b0;

    do_reset(1, "reset_a");
    do_reset(3, "reset_b");

    // Load-use with single-cycle stall
    idle(1, "lu1_idle", DEF);
    step(1, "lu1_hazard", 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, BUB_R);
    idle(1, "lu1_after", DEF);

    // Three-cycle stall via rt, then non-hazard cases and branch-over-hazard
    do_reset(3, "reset_lu3");
    step(3, "lu3_b1", 1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, BUB_R);
    step(3, "lu3_b2", 1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, BUB_S);
    step(3, "lu3_b3", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, BUB_S);
    idle(3, "lu3_release", DEF);
    step(3, "rt_no_use", 1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, DEF);
    step(3, "rt_zero", 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, DEF);
    step(3, "branch_hazard", 1'b0, 1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 11'b11_0_111_0_0_00);
    idle(3, "branch_after", DEF);

    // Four-cycle memory access: three held cycles
    do_reset(1, "reset_miss");
    step(1, "miss_c1", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, HOLD_R);
    step(1, "miss_c2", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, HOLD_W);
    step(1, "miss_c3", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, HOLD_W);
    step(1, "miss_ack", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 11'b11_0_000_0_0_10);
    idle(1, "miss_after", DEF);
`ifdef HAZARD_STALL_CNT_EN
    exp_cnt = 32'd3;
`else
    exp_cnt = 32'd0;
`endif
    total++;
    assert (scnt[1] === exp_cnt) else begin
      bad++;
      $error("[TB] FAIL stall_cnt: observed=%0d expected=%0d", scnt[1], exp_cnt);
    end

    // Timeout: 16 held cycles then sticky error until reset
    do_reset(1, "reset_tmo");
    step(1, "tmo_first", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, HOLD_R);
    for (int i = 1; i < 16; i++) begin
      step(1, $sformatf("tmo_wait%0d", i), 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, HOLD_W);
    end
    step(1, "tmo_err", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, ERRV);
    idle(1, "tmo_sticky", ERRV);
    do_reset(1, "tmo_reset");
    idle(1, "tmo_recover", DEF);

    // Miss arriving during a two-cycle load-use stall
    do_reset(2, "reset_lu2");
    step(2, "lu2_hazard", 1'b0, 1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, BUB_R);
    step(2, "lu2_miss", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 11'b00_0_000_1_0_01);
    step(2, "lu2_ack", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 11'b00_1_000_0_0_10);
    idle(2, "lu2_after", DEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline hazard and stall controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB). Sits beside the instruction decoder and pipeline registers. Sequences PC/IF-ID write enables, ID/EX bubble insertion, branch flushes and whole-pipe holds for multi-cycle data-memory accesses. A memory-timeout watchdog parks the pipe in an error state.

## Interface
- LU_STALL_CYCLES, 1: bubbles inserted per load-use hazard; legal 1..15.
- MEM_TIMEOUT, 16: held cycles before the error state; legal 2..255.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- idex_memread_i  in  1  instruction in EX is a load (LW).
- idex_rt_i  in  5  destination rt of that instruction.
- ifid_rs_i  in  5  rs of the instruction in ID.
- ifid_rt_i  in  5  rt of the instruction in ID.
- ifid_uses_rt_i  in  1  ID instruction reads rt (R-type, SW, BEQ).
- branch_taken_i  in  1  BEQ in MEM resolved taken.
- dmem_req_i  in  1  MEM stage accessing data memory (MemRead|MemWrite).
- dmem_ack_i  in  1  data memory completes access this cycle.
- pc_write_o  out  1  PC update enable.
- ifid_write_o  out  1  IF/ID register write enable.
- idex_bubble_o  out  1  zero control fields entering ID/EX.
- ifid_flush_o, idex_flush_o, exmem_flush_o  out  1 each  clear respective pipeline register.
- pipe_hold_o  out  1  freeze ID/EX, EX/MEM, MEM/WB.
- err_o  out  1  sticky memory-timeout error.
- state_o  out  2  current state encoding.
- stall_cnt_o  out  32  stall-cycle counter (see Configuration).

## Operation
- States: RUN=0, STALL=1, MEM_WAIT=2, ERR=3. Registers: state, lu_cnt (4b), wait_cnt (8b), ret_state (1b: RUN/STALL), err.
- Hazard H = idex_memread_i & (idex_rt_i!=0) & ((idex_rt_i==ifid_rs_i) | (ifid_uses_rt_i & idex_rt_i==ifid_rt_i)).
- Miss M = dmem_req_i & ~dmem_ack_i.
- Defaults, unless overridden below: pc_write=1, ifid_write=1, all others 0.
- RUN, in priority order:
  - M: pc_write=0, ifid_write=0, pipe_hold=1; ret_state=RUN; wait_cnt=1; next MEM_WAIT.
  - branch_taken_i: all three flushes=1, pc_write=1; H ignored; stay RUN.
  - H: pc_write=0, ifid_write=0, idex_bubble=1. If LU_STALL_CYCLES>1, lu_cnt=LU_STALL_CYCLES-1 and next STALL; else stay RUN.
  - Otherwise defaults.
- STALL:
  - M: hold as above; ret_state=STALL; lu_cnt frozen; next MEM_WAIT.
  - Otherwise pc_write=0, ifid_write=0, idex_bubble=1; lu_cnt decrements; lu_cnt==1 -> RUN.
- MEM_WAIT:
  - While M: pc_write=0, ifid_write=0, pipe_hold=1; wait_cnt increments. If wait_cnt==MEM_TIMEOUT-1 with M still high, next ERR.
  - On dmem_ack_i: wait_cnt=0; outputs and next state per ret_state's rules above, skipping the M row.
- ERR: pc_write=0, ifid_write=0, pipe_hold=1, err_o=1; exit only via rst_i.
- branch_taken_i with dmem_req_i is illegal (BEQ makes no memory access). Memory rules take priority; the branch is dropped.

## Timing
- All outputs are combinational from state plus same-cycle inputs (Mealy); zero latency from H/M/branch to controls.
- Reset: while rst_i=1, pc_write_o=0, ifid_write_o=0, all other outputs 0. Next edge: state=RUN, lu_cnt=0, wait_cnt=0, err=0, stall_cnt=0.
- Reset mid-STALL, MEM_WAIT or ERR: abandoned at that edge, no residual bubble.
- One load-use hazard costs exactly LU_STALL_CYCLES cycles of pc_write_o=0.
- An N-cycle memory miss (ack on the Nth cycle after req) costs N-1 held cycles.
- Timeout: err_o rises MEM_TIMEOUT cycles after the first held cycle.

## Configuration
- HAZARD_STALL_CNT_EN defined: stall_cnt_o counts every cycle with pc_write_o=0 and rst_i=0; saturates at 0xFFFFFFFF; cleared by reset.
- Undefined: no counter logic; stall_cnt_o tied to 0.

## Test plan
- Load-use, default params: idex_memread=1, idex_rt=5, ifid_rs=5 -> one cycle pc_write=0, ifid_write=0, idex_bubble=1, state stays 0; next cycle defaults.
- LU_STALL_CYCLES=3, ifid_uses_rt=1, rt match -> exactly 3 bubble cycles, state_o 0->1->1->0; rt match with ifid_uses_rt=0 -> no stall; idex_rt=0 -> no stall.
- Branch plus hazard same cycle: branch_taken=1, H=1 -> three flushes=1, pc_write=1, no bubble.
- Memory miss: dmem_req=1, ack after 4 cycles -> 3 held cycles with pipe_hold=1, state 2, then RUN; with HAZARD_STALL_CNT_EN, stall_cnt_o=3.
- Timeout: dmem_req=1, ack never, MEM_TIMEOUT=16 -> err_o=1 and state 3 after 16 held cycles; rst_i pulse -> RUN, err_o=0, pc_write_o=1.
- Miss during STALL (LU_STALL_CYCLES=2): M in the STALL cycle -> hold, then ack -> remaining bubble issued, then RUN.
